// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM access stage: word width, FSM state
// encodings and a small address-alignment helper.
package mem_access_stage_pkg;

   localparam int WORD_LEN = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic isWordAligned(input logic [1:0] lowBits);
      return (lowBits == 2'b00);
   endfunction

endpackage

// File: rtl/mem_access_stage_timeout.sv
// Cycle counter bounding how long the MEM stage waits for a memory ack;
// expired is raised once the count reaches TIMEOUT.
module access_timeout_counter #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT);

   logic [7:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_count <= 8'd0;
      end else if (en) begin
         r_count <= r_count + 8'd1;
      end
   end

   assign expired = (r_count == LIMIT);

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: turns EX/MEM load/store commands into a req/ack
// transaction, freezing upstream until the memory answers or times out.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int WORD_LEN = mem_access_stage_pkg::WORD_LEN,
   parameter int TIMEOUT  = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                MEM_R_EN,
   input  logic                MEM_W_EN,
   input  logic [WORD_LEN-1:0] ALU_Result,
   input  logic [WORD_LEN-1:0] Store_Value,
   output logic                mem_req,
   output logic                mem_we,
   output logic [WORD_LEN-1:0] mem_addr,
   output logic [WORD_LEN-1:0] mem_wdata,
   input  logic                mem_ack,
   input  logic [WORD_LEN-1:0] mem_rdata,
   output logic                freeze,
   output logic [WORD_LEN-1:0] MEM_Result,
   output logic                mem_done,
   output logic                mem_err
);

   state_t r_state;

   logic w_anyEn;
   logic w_valid;
   logic w_illegal;
   logic w_launch;
   logic w_expired;

   assign w_anyEn   = MEM_R_EN | MEM_W_EN;
   assign w_valid   = (MEM_R_EN ^ MEM_W_EN) & isWordAligned(ALU_Result[1:0]);
   assign w_illegal = w_anyEn & ~w_valid;
   assign w_launch  = (r_state == IDLE) & w_valid;

   // Upstream only waits for accesses actually in flight; illegal commands pass through.
   assign freeze = w_launch | (r_state == REQ);

   // Counting starts on the launch cycle so expiry lands on the TIMEOUT-th request cycle.
   access_timeout_counter #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clr    (r_state == DONE),
      .en     (w_launch | (r_state == REQ)),
      .expired(w_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         MEM_Result <= '0;
         mem_done   <= 1'b0;
         mem_err    <= 1'b0;
      end else begin
         mem_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_valid) begin
                  mem_addr  <= ALU_Result;
                  mem_wdata <= Store_Value;
                  mem_we    <= MEM_W_EN;
                  mem_req   <= 1'b1;
                  r_state   <= REQ;
               end else if (w_illegal) begin
                  mem_err <= 1'b1;
               end
            end
            REQ: begin
               // An ack on the expiry cycle still counts as a successful access.
               if (mem_ack) begin
                  mem_req  <= 1'b0;
                  mem_done <= 1'b1;
                  if (!mem_we) begin
                     MEM_Result <= mem_rdata;
                  end
                  r_state <= DONE;
               end else if (w_expired) begin
                  mem_req  <= 1'b0;
                  mem_err  <= 1'b1;
                  mem_done <= 1'b1;
                  r_state  <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with TIMEOUT=4: loads, stores,
// illegal commands, timeout, ack/timeout collision and mid-access reset.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        MEM_R_EN;
   logic        MEM_W_EN;
   logic [31:0] ALU_Result;
   logic [31:0] Store_Value;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        freeze;
   logic [31:0] MEM_Result;
   logic        mem_done;
   logic        mem_err;

   int totalChecks  = 0;
   int passedChecks = 0;

   mem_access_stage #(
      .WORD_LEN(32),
      .TIMEOUT (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .MEM_R_EN   (MEM_R_EN),
      .MEM_W_EN   (MEM_W_EN),
      .ALU_Result (ALU_Result),
      .Store_Value(Store_Value),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .freeze     (freeze),
      .MEM_Result (MEM_Result),
      .mem_done   (mem_done),
      .mem_err    (mem_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic rEn, input logic wEn,
                                input logic [31:0] addr, input logic [31:0] data);
      MEM_R_EN    = rEn;
      MEM_W_EN    = wEn;
      ALU_Result  = addr;
      Store_Value = data;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      totalChecks++;
      assert (observed === expected) begin
         passedChecks++;
      end else begin
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      rst       = 1'b1;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      checkOutput("reset_req", {31'd0, mem_req}, 32'd0);
      checkOutput("reset_we", {31'd0, mem_we}, 32'd0);
      checkOutput("reset_addr", mem_addr, 32'd0);
      checkOutput("reset_wdata", mem_wdata, 32'd0);
      checkOutput("reset_result", MEM_Result, 32'd0);
      checkOutput("reset_done", {31'd0, mem_done}, 32'd0);
      checkOutput("reset_err", {31'd0, mem_err}, 32'd0);
      checkOutput("reset_freeze", {31'd0, freeze}, 32'd0);

      $display("[TB] aligned load, ack after 3 cycles");
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0);
      checkOutput("ld_c0_freeze", {31'd0, freeze}, 32'd1);
      checkOutput("ld_c0_req", {31'd0, mem_req}, 32'd0);
      tick();
      checkOutput("ld_c1_req", {31'd0, mem_req}, 32'd1);
      checkOutput("ld_c1_we", {31'd0, mem_we}, 32'd0);
      checkOutput("ld_c1_addr", mem_addr, 32'h0000_0010);
      checkOutput("ld_c1_freeze", {31'd0, freeze}, 32'd1);
      tick();
      checkOutput("ld_c2_req", {31'd0, mem_req}, 32'd1);
      tick();
      mem_ack   = 1'b1;
      mem_rdata = 32'h1234_5678;
      checkOutput("ld_c3_req", {31'd0, mem_req}, 32'd1);
      checkOutput("ld_c3_freeze", {31'd0, freeze}, 32'd1);
      checkOutput("ld_c3_done", {31'd0, mem_done}, 32'd0);
      tick();
      mem_ack = 1'b0;
      checkOutput("ld_c4_done", {31'd0, mem_done}, 32'd1);
      checkOutput("ld_c4_freeze", {31'd0, freeze}, 32'd0);
      checkOutput("ld_c4_req", {31'd0, mem_req}, 32'd0);
      checkOutput("ld_c4_result", MEM_Result, 32'h1234_5678);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      checkOutput("ld_c5_done", {31'd0, mem_done}, 32'd0);

      $display("[TB] aligned store, ack on first request cycle");
      applyStimulus(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D);
      checkOutput("st_c0_freeze", {31'd0, freeze}, 32'd1);
      tick();
      mem_ack   = 1'b1;
      mem_rdata = 32'h5555_AAAA;
      checkOutput("st_c1_req", {31'd0, mem_req}, 32'd1);
      checkOutput("st_c1_we", {31'd0, mem_we}, 32'd1);
      checkOutput("st_c1_wdata", mem_wdata, 32'hCAFE_F00D);
      checkOutput("st_c1_addr", mem_addr, 32'h0000_0020);
      tick();
      mem_ack = 1'b0;
      checkOutput("st_c2_done", {31'd0, mem_done}, 32'd1);
      checkOutput("st_c2_result", MEM_Result, 32'h1234_5678);
      checkOutput("st_c2_err", {31'd0, mem_err}, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      $display("[TB] ack while idle");
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_ack = 1'b0;
      checkOutput("idle_ack_result", MEM_Result, 32'h1234_5678);
      checkOutput("idle_ack_done", {31'd0, mem_done}, 32'd0);
      checkOutput("idle_ack_req", {31'd0, mem_req}, 32'd0);
      checkOutput("idle_ack_err", {31'd0, mem_err}, 32'd0);

      $display("[TB] ack coincident with final timeout cycle");
      applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0);
      tick();
      tick();
      tick();
      tick();
      mem_ack   = 1'b1;
      mem_rdata = 32'h0BAD_CAFE;
      checkOutput("coll_c4_req", {31'd0, mem_req}, 32'd1);
      tick();
      mem_ack = 1'b0;
      checkOutput("coll_c5_done", {31'd0, mem_done}, 32'd1);
      checkOutput("coll_c5_result", MEM_Result, 32'h0BAD_CAFE);
      checkOutput("coll_c5_err", {31'd0, mem_err}, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      $display("[TB] misaligned load");
      applyStimulus(1'b1, 1'b0, 32'h0000_0013, 32'h0);
      checkOutput("mis_c0_freeze", {31'd0, freeze}, 32'd0);
      tick();
      checkOutput("mis_c1_req", {31'd0, mem_req}, 32'd0);
      checkOutput("mis_c1_err", {31'd0, mem_err}, 32'd1);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      checkOutput("mis_c2_err_sticky", {31'd0, mem_err}, 32'd1);

      $display("[TB] both enables set");
      applyStimulus(1'b1, 1'b1, 32'h0000_0030, 32'h1111_2222);
      checkOutput("both_freeze", {31'd0, freeze}, 32'd0);
      tick();
      checkOutput("both_req", {31'd0, mem_req}, 32'd0);
      checkOutput("both_err", {31'd0, mem_err}, 32'd1);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      $display("[TB] load timeout, no ack");
      applyStimulus(1'b1, 1'b0, 32'h0000_0050, 32'h0);
      for (int c = 1; c <= 4; c++) begin
         tick();
         checkOutput($sformatf("to_c%0d_req", c), {31'd0, mem_req}, 32'd1);
         checkOutput($sformatf("to_c%0d_freeze", c), {31'd0, freeze}, 32'd1);
      end
      tick();
      checkOutput("to_c5_req", {31'd0, mem_req}, 32'd0);
      checkOutput("to_c5_done", {31'd0, mem_done}, 32'd1);
      checkOutput("to_c5_freeze", {31'd0, freeze}, 32'd0);
      checkOutput("to_c5_result", MEM_Result, 32'h0BAD_CAFE);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      checkOutput("to_c6_done", {31'd0, mem_done}, 32'd0);

      $display("[TB] reset during pending load");
      applyStimulus(1'b1, 1'b0, 32'h0000_0060, 32'h0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("rst_req", {31'd0, mem_req}, 32'd0);
      checkOutput("rst_addr", mem_addr, 32'd0);
      checkOutput("rst_result", MEM_Result, 32'd0);
      checkOutput("rst_err", {31'd0, mem_err}, 32'd0);
      checkOutput("rst_freeze", {31'd0, freeze}, 32'd0);
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      tick();
      mem_ack = 1'b0;
      checkOutput("rst_late_ack_result", MEM_Result, 32'd0);
      checkOutput("rst_late_ack_done", {31'd0, mem_done}, 32'd0);
      checkOutput("rst_late_ack_req", {31'd0, mem_req}, 32'd0);

      $display("%0d/%0d checks passed", passedChecks, totalChecks);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage directly downstream of the execute stage.
- Consumes the ALU result as a word address and the forwarded store value as write data.
- Runs a req/ack handshake to a variable-latency data memory and freezes the upstream pipeline until the access completes.
- Presents the loaded word and a one-cycle completion pulse toward write-back; flags misaligned, illegal and timed-out accesses.

Parameters:
- WORD_LEN, 32, data/address width; taken from the shared `WORD_LEN define.
- TIMEOUT, 255, max cycles waiting for mem_ack before the access is aborted (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- MEM_R_EN  input  1  load request from the EX/MEM register.
- MEM_W_EN  input  1  store request from the EX/MEM register.
- ALU_Result  input  WORD_LEN  access address (byte address).
- Store_Value  input  WORD_LEN  store data.
- mem_req  output  1  request to data memory.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  output  WORD_LEN  latched address.
- mem_wdata  output  WORD_LEN  latched store data.
- mem_ack  input  1  memory completion; one cycle.
- mem_rdata  input  WORD_LEN  read data; valid with mem_ack.
- freeze  output  1  stall upstream stages and the EX/MEM register.
- MEM_Result  output  WORD_LEN  last loaded word.
- mem_done  output  1  one-cycle pulse: access finished.
- mem_err  output  1  sticky error flag.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, MEM_Result=0, mem_done=0, mem_err=0.
  - Timeout counter=0.
  - Takes effect mid-access: mem_req drops the next cycle and any later mem_ack is ignored.
- freeze is combinational:
  - 1 in IDLE when a valid command is present.
  - 1 throughout REQ.
  - 0 in DONE and otherwise.
- Upstream holds MEM_R_EN, MEM_W_EN, ALU_Result and Store_Value stable while freeze=1.
- IDLE:
  - Valid command: exactly one of R_EN/W_EN set and ALU_Result[1:0]==0.
  - On a valid command, latch addr, wdata and we=W_EN; assert mem_req registered; go to REQ.
  - Misaligned, or both enables set: no access, mem_err<=1, freeze=0, stay IDLE.
  - Neither enable set: stay IDLE.
- REQ:
  - mem_req=1; counter increments each cycle.
  - mem_ack=1: mem_req<=0; if read, MEM_Result<=mem_rdata; go to DONE.
  - Counter reaches TIMEOUT without ack: mem_req<=0, mem_err<=1, MEM_Result unchanged; go to DONE.
  - An ack arriving in the same cycle as the timeout takes priority (treated as success).
- DONE:
  - mem_done=1 for exactly this cycle; freeze=0 so the pipeline advances.
  - Go to IDLE; counter cleared.
  - A new command cannot start before IDLE (minimum 1 bubble-free gap because the register advances this cycle).
- Latency:
  - Command seen at cycle 0 gives mem_req at cycle 1.
  - Ack at cycle k gives mem_done at cycle k+1.
  - freeze is high for cycles 0..k inclusive.
- Writes leave MEM_Result unchanged.
- mem_ack outside REQ is ignored.
- mem_err is cleared only by rst.

Decomposition:
- Shared defines header: WORD_LEN and the state encodings IDLE=2'd0, REQ=2'd1, DONE=2'd2.
- One natural sub-module: access_timeout_counter.
  - Inputs: clr, en.
  - Output: expired, asserted when count==TIMEOUT.
- The FSM, address/data latches and output registers stay in mem_access_stage.

Test Plan:
1. Aligned load, addr=0x0000_0010, ack after 3 cycles with rdata=0x1234_5678 -> mem_req high cycles 1-3, mem_we=0, freeze high cycles 0-3, mem_done at cycle 4, MEM_Result=0x1234_5678.
2. Aligned store, addr=0x20, data=0xCAFE_F00D, ack on cycle 1 -> mem_we=1, mem_wdata=0xCAFE_F00D, mem_done at cycle 2, MEM_Result unchanged, mem_err=0.
3. Load at addr=0x0000_0013 -> no mem_req, freeze=0, mem_err=1 next cycle and stays 1 until rst.
4. R_EN=W_EN=1 -> no access, mem_err=1; then a timeout case with TIMEOUT=4 and no ack -> mem_req for 4 cycles, then dropped, mem_done pulse, MEM_Result unchanged.
5. Ack coincident with the final timeout cycle -> treated as success, MEM_Result=rdata; also an ack while IDLE -> no effect on any output.
6. rst asserted in cycle 2 of a pending load -> all outputs zero next cycle, state IDLE; a later ack is ignored and MEM_Result stays 0.
